divide_seq: RTL

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/divide_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/divide_seq.sv
// Sequential non-restoring divider: signed/unsigned WIDTH-bit operands,
// one quotient bit per clock, result packed as {remainder, quotient}.
module divide_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q;
  logic [WIDTH:0]       a_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     m_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 ovf_pend_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic                 ovf_q;

  logic                 dvd_neg_d;
  logic                 dvs_neg_d;
  logic [WIDTH-1:0]     dvd_mag_d;
  logic [WIDTH-1:0]     dvs_mag_d;
  logic                 ovf_d;
  logic [WIDTH:0]       a_shift_d;
  logic [WIDTH:0]       a_step_d;
  logic [WIDTH-1:0]     q_step_d;
  logic [WIDTH:0]       a_fix_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     rem_d;

  // Operand conditioning: unsigned magnitudes; the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    dvd_neg_d = signed_op & dividend[WIDTH-1];
    dvs_neg_d = signed_op & divisor[WIDTH-1];
    dvd_mag_d = dvd_neg_d ? WIDTH'(~dividend + 1'b1) : dividend;
    dvs_mag_d = dvs_neg_d ? WIDTH'(~divisor + 1'b1) : divisor;
    ovf_d     = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});
  end

  // One non-restoring iteration; A wraps mod 2^(WIDTH+1) but always settles in [-M, M)
  always_comb begin
    a_shift_d = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_step_d  = a_q[WIDTH] ? (a_shift_d + {1'b0, m_q}) : (a_shift_d - {1'b0, m_q});
    q_step_d  = {q_q[WIDTH-2:0], ~a_step_d[WIDTH]};
  end

  // Final restore and sign application (truncating division)
  always_comb begin
    a_fix_d = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;
    quo_d   = neg_quo_q ? WIDTH'(~q_q + 1'b1) : q_q;
    rem_d   = neg_rem_q ? WIDTH'(~a_fix_d[WIDTH-1:0] + 1'b1) : a_fix_d[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              result_q <= {dividend, {WIDTH{1'b1}}};
              dbz_q    <= 1'b1;
              ovf_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              a_q        <= '0;
              q_q        <= dvd_mag_d;
              m_q        <= dvs_mag_d;
              cnt_q      <= '0;
              neg_quo_q  <= dvd_neg_d ^ dvs_neg_d;
              neg_rem_q  <= dvd_neg_d;
              ovf_pend_q <= ovf_d;
              busy_q     <= 1'b1;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          a_q   <= a_step_d;
          q_q   <= q_step_d;
          cnt_q <= CW'(cnt_q + 1'b1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          a_q      <= a_fix_d;
          result_q <= {rem_d, quo_d};
          dbz_q    <= 1'b0;
          ovf_q    <= ovf_pend_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
